dvi_link_sequencer: RTL and testbench
=====================================

// Module: dvi_link_sequencer
// PURPOSE
//  Bring-up and supervision FSM for the DVI output path, in the pixel clock domain.
//  - Waits for a stable PLL lock, then releases the datapath reset.
//  - Lets the datapath settle, then enables the video timing generator.
//  - Enables the TMDS output drivers only at a frame boundary.
//  - On PLL lock loss: drops everything at once, counts the fault, holds off, then retries.
//  Sits between the PLL/reset resources and smoldvi_top in the FPGA top level.
// PARAMETERS
//  W_CNT          16    width of the shared delay counter; every *_CYCLES value must be < 2**W_CNT
//  LOCK_CYCLES    1024  consecutive cycles of synchronised lock required (>=1)
//  SETTLE_CYCLES  16    cycles spent in SETTLE (>=1)
//  HOLDOFF_CYCLES 4096  cycles spent in HOLDOFF after a lock loss (>=1)
// PORTS
//  clk          in   1  pixel clock; single clock domain
//  rst          in   1  asynchronous reset, active-high
//  pll_lock     in   1  asynchronous PLL lock; passes a 2-flop synchroniser (lock_s), latency 2 cycles
//  enable       in   1  synchronous master enable
//  frame_start  in   1  one-cycle pulse from the timing generator at frame start
//  dp_rst_n     out  1  datapath reset, active-low
//  timing_en    out  1  timing generator enable
//  tmds_oe      out  1  TMDS output driver enable
//  state        out  3  current FSM state code
//  fault_count  out  8  number of lock-loss faults, saturating
// BEHAVIOUR
//  Reset (async, immediate, no clock edge needed):
//   state=OFF, all outputs 0, counter=0, sync flops=0, fault_count=0.
//  States: OFF=0, WAIT_LOCK=1, SETTLE=2, WAIT_FRAME=3, RUN=4, HOLDOFF=5.
//   Codes 6 and 7 are illegal and go to OFF on the next edge.
//  Outputs are registered, decoded from next-state, so they change on the same edge the state is entered:
//   dp_rst_n  = 1 in SETTLE, WAIT_FRAME, RUN
//   timing_en = 1 in WAIT_FRAME, RUN
//   tmds_oe   = 1 in RUN
//  The counter clears on every state change.
//  OFF: stays while enable=0. enable=1 -> WAIT_LOCK.
//  WAIT_LOCK:
//   - lock_s=1: counter increments.
//   - lock_s=0: counter clears.
//   - Edge with lock_s=1 and counter==LOCK_CYCLES-1 -> SETTLE.
//   - A lock drop here is not a fault.
//  SETTLE: exactly SETTLE_CYCLES cycles, then -> WAIT_FRAME.
//  WAIT_FRAME:
//   - The edge that samples frame_start=1 -> RUN.
//   - No timeout.
//   - frame_start is ignored in every other state.
//  RUN: stays while lock_s=1 and enable=1.
//  Lock loss: lock_s=0 in SETTLE, WAIT_FRAME or RUN -> HOLDOFF on the next edge, and fault_count += 1.
//  HOLDOFF:
//   - Exactly HOLDOFF_CYCLES cycles; lock_s and enable are not sampled for exit.
//   - Then -> WAIT_LOCK if enable=1, else -> OFF.
//  enable=0 in WAIT_LOCK, SETTLE, WAIT_FRAME or RUN -> OFF on the next edge; no fault counted.
//  Priority: lock loss > enable drop. If both happen together -> HOLDOFF, fault counted, then OFF.
//  fault_count saturates at 255 and never wraps. Only rst clears it.
// TESTING (LOCK_CYCLES=8, SETTLE_CYCLES=4, HOLDOFF_CYCLES=16)
//  1. Bring-up: enable=1, pll_lock rises after edge 0.
//     -> SETTLE entered at edge 10: dp_rst_n=1, state=2.
//     -> Edge 14: timing_en=1, state=3.
//     -> Pulse frame_start -> tmds_oe=1 and state=4 on that edge.
//  2. Glitch in WAIT_LOCK: lock high 5 cycles, low 1, high again.
//     -> Counter restarts; SETTLE is entered 8 lock_s-high cycles later.
//     -> fault_count stays 0.
//  3. Lock loss in RUN:
//     -> 2 cycles later one edge sets dp_rst_n=0, timing_en=0, tmds_oe=0, state=5, fault_count=1.
//     -> 16 cycles later state=1.
//  4. enable=0 in RUN -> state=0, all outputs 0, fault_count unchanged.
//     enable=0 together with lock loss -> state=5, fault +1, then state=0 after 16 cycles.
//  5. 260 lock-loss events -> fault_count=255. frame_start pulses outside WAIT_FRAME have no effect.
//  6. rst pulsed mid-RUN, between clock edges -> outputs, state and fault_count go to 0 immediately.
//     After rst falls, bring-up repeats as in test 1.

Source files
------------

// File: rtl/dvi_link_sequencer_if.sv
// rtl/dvi_link_sequencer_if.sv - control/status bundle between the DVI link sequencer and its surroundings
// master drives the PLL lock, enable and frame strobe; slave (the sequencer) returns the enables and status.
interface dvi_link_sequencer_if;
   logic       pll_lock;
   logic       enable;
   logic       frame_start;
   logic       dp_rst_n;
   logic       timing_en;
   logic       tmds_oe;
   logic [2:0] state;
   logic [7:0] fault_count;

   modport master (
      output pll_lock,
      output enable,
      output frame_start,
      input  dp_rst_n,
      input  timing_en,
      input  tmds_oe,
      input  state,
      input  fault_count
   );

   modport slave (
      input  pll_lock,
      input  enable,
      input  frame_start,
      output dp_rst_n,
      output timing_en,
      output tmds_oe,
      output state,
      output fault_count
   );
endinterface

// File: rtl/dvi_link_sequencer.sv
// rtl/dvi_link_sequencer.sv - bring-up and lock-loss supervision FSM for the DVI output path
// Releases datapath reset, timing and TMDS drivers in order; backs off and retries on PLL lock loss.
module dvi_link_sequencer #(
   parameter int unsigned W_CNT          = 16,
   parameter int unsigned LOCK_CYCLES    = 1024,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned HOLDOFF_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   dvi_link_sequencer_if.slave  link
);

   typedef enum logic [2:0] {
      ST_OFF        = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_SETTLE     = 3'd2,
      ST_WAIT_FRAME = 3'd3,
      ST_RUN        = 3'd4,
      ST_HOLDOFF    = 3'd5
   } state_e;

   localparam logic [W_CNT-1:0] LOCK_LAST    = W_CNT'(LOCK_CYCLES - 1);
   localparam logic [W_CNT-1:0] SETTLE_LAST  = W_CNT'(SETTLE_CYCLES - 1);
   localparam logic [W_CNT-1:0] HOLDOFF_LAST = W_CNT'(HOLDOFF_CYCLES - 1);

   state_e           state_q, state_d;
   logic [W_CNT-1:0] cnt_q, cnt_d;
   logic [7:0]       fault_q, fault_d;
   logic             lock_meta_q, lock_s_q;
   logic             dp_rst_n_q, timing_en_q, tmds_oe_q;
   logic             lock_lost;

   // The counter only survives an edge where the state holds; any transition restarts it at zero.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      fault_d   = fault_q;
      lock_lost = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (link.enable) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (!link.enable) begin
               state_d = ST_OFF;
            end else if (lock_s_q) begin
               if (cnt_q == LOCK_LAST) state_d = ST_SETTLE;
               else                    cnt_d   = cnt_q + W_CNT'(1);
            end
         end
         ST_SETTLE: begin
            if (!lock_s_q)                 lock_lost = 1'b1;
            else if (!link.enable)         state_d   = ST_OFF;
            else if (cnt_q == SETTLE_LAST) state_d   = ST_WAIT_FRAME;
            else                           cnt_d     = cnt_q + W_CNT'(1);
         end
         ST_WAIT_FRAME: begin
            if (!lock_s_q)             lock_lost = 1'b1;
            else if (!link.enable)     state_d   = ST_OFF;
            else if (link.frame_start) state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (!lock_s_q)         lock_lost = 1'b1;
            else if (!link.enable) state_d   = ST_OFF;
         end
         ST_HOLDOFF: begin
            if (cnt_q == HOLDOFF_LAST) state_d = link.enable ? ST_WAIT_LOCK : ST_OFF;
            else                       cnt_d   = cnt_q + W_CNT'(1);
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase

      // Lock loss outranks an enable drop: the fault is always recorded.
      if (lock_lost) begin
         state_d = ST_HOLDOFF;
         if (fault_q != 8'hFF) fault_d = fault_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         fault_q     <= '0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         dp_rst_n_q  <= 1'b0;
         timing_en_q <= 1'b0;
         tmds_oe_q   <= 1'b0;
      end else begin
         lock_meta_q <= link.pll_lock;
         lock_s_q    <= lock_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fault_q     <= fault_d;
         dp_rst_n_q  <= (state_d == ST_SETTLE) || (state_d == ST_WAIT_FRAME) || (state_d == ST_RUN);
         timing_en_q <= (state_d == ST_WAIT_FRAME) || (state_d == ST_RUN);
         tmds_oe_q   <= (state_d == ST_RUN);
      end
   end

   assign link.dp_rst_n    = dp_rst_n_q;
   assign link.timing_en   = timing_en_q;
   assign link.tmds_oe     = tmds_oe_q;
   assign link.state       = state_q;
   assign link.fault_count = fault_q;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// tb/tb_dvi_link_sequencer.sv - directed self-checking bench for dvi_link_sequencer
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dvi_link_sequencer;

   logic clk;
   logic rst;
   int   tests;
   int   failed;

   dvi_link_sequencer_if link ();

   dvi_link_sequencer #(
      .W_CNT         (16),
      .LOCK_CYCLES   (8),
      .SETTLE_CYCLES (4),
      .HOLDOFF_CYCLES(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .link(link)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] st, input logic dp,
                            input logic te, input logic oe);
      check({tag, ".state"},     32'(link.state),     32'(st));
      check({tag, ".dp_rst_n"},  32'(link.dp_rst_n),  32'(dp));
      check({tag, ".timing_en"}, 32'(link.timing_en), 32'(te));
      check({tag, ".tmds_oe"},   32'(link.tmds_oe),   32'(oe));
   endtask

   initial begin
      tests            = 0;
      failed           = 0;
      rst              = 1'b1;
      link.pll_lock    = 1'b0;
      link.enable      = 1'b0;
      link.frame_start = 1'b0;

      // reset state
      #2;
      check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
      check("reset.fault", 32'(link.fault_count), 32'd0);
      tick(2);

      // 1: bring-up, edge 0 is the first edge after release
      rst         = 1'b0;
      link.enable = 1'b1;
      tick(1);
      check_out("t1.edge0", 3'd1, 1'b0, 1'b0, 1'b0);
      link.pll_lock = 1'b1;
      tick(9);
      check_out("t1.edge9", 3'd1, 1'b0, 1'b0, 1'b0);
      tick(1);
      check_out("t1.edge10", 3'd2, 1'b1, 1'b0, 1'b0);
      tick(3);
      check_out("t1.edge13", 3'd2, 1'b1, 1'b0, 1'b0);
      tick(1);
      check_out("t1.edge14", 3'd3, 1'b1, 1'b1, 1'b0);
      tick(3);
      check_out("t1.no_frame", 3'd3, 1'b1, 1'b1, 1'b0);
      link.frame_start = 1'b1;
      tick(1);
      link.frame_start = 1'b0;
      check_out("t1.run", 3'd4, 1'b1, 1'b1, 1'b1);

      // 4a: enable drop in RUN
      link.enable = 1'b0;
      tick(1);
      check_out("t4a.off", 3'd0, 1'b0, 1'b0, 1'b0);
      check("t4a.fault", 32'(link.fault_count), 32'd0);

      // 2: glitch in WAIT_LOCK restarts the lock count
      link.pll_lock = 1'b0;
      tick(3);
      link.enable = 1'b1;
      tick(1);
      check("t2.wait_lock", 32'(link.state), 32'd1);
      link.pll_lock = 1'b1;
      tick(5);
      link.pll_lock = 1'b0;
      tick(1);
      link.pll_lock = 1'b1;
      tick(9);
      check("t2.still_waiting", 32'(link.state), 32'd1);
      tick(1);
      check_out("t2.settle", 3'd2, 1'b1, 1'b0, 1'b0);
      check("t2.fault", 32'(link.fault_count), 32'd0);
      tick(4);
      check("t2.wait_frame", 32'(link.state), 32'd3);
      link.frame_start = 1'b1;
      tick(1);
      link.frame_start = 1'b0;
      check("t2.run", 32'(link.state), 32'd4);

      // 3: lock loss in RUN
      link.pll_lock = 1'b0;
      tick(2);
      check("t3.sync_delay", 32'(link.state), 32'd4);
      tick(1);
      check_out("t3.holdoff", 3'd5, 1'b0, 1'b0, 1'b0);
      check("t3.fault", 32'(link.fault_count), 32'd1);
      link.pll_lock = 1'b1;
      tick(15);
      check("t3.holdoff_end", 32'(link.state), 32'd5);
      tick(1);
      check("t3.retry", 32'(link.state), 32'd1);
      tick(8);
      check("t3.settle", 32'(link.state), 32'd2);

      // 5a: frame_start in SETTLE is ignored
      link.frame_start = 1'b1;
      tick(1);
      link.frame_start = 1'b0;
      check("t5.fs_settle", 32'(link.state), 32'd2);
      tick(3);
      check("t3.wait_frame", 32'(link.state), 32'd3);
      link.frame_start = 1'b1;
      tick(1);
      link.frame_start = 1'b0;
      check("t3.run", 32'(link.state), 32'd4);

      // 4b: enable drop together with lock loss
      link.pll_lock = 1'b0;
      tick(2);
      link.enable = 1'b0;
      tick(1);
      check_out("t4b.holdoff", 3'd5, 1'b0, 1'b0, 1'b0);
      check("t4b.fault", 32'(link.fault_count), 32'd2);
      link.pll_lock = 1'b1;
      tick(15);
      check("t4b.holdoff_end", 32'(link.state), 32'd5);
      tick(1);
      check_out("t4b.off", 3'd0, 1'b0, 1'b0, 1'b0);

      // 5: repeated lock loss from SETTLE saturates the fault counter
      link.enable = 1'b1;
      tick(1);
      for (int i = 1; i <= 258; i++) begin
         tick(8);
         link.pll_lock = 1'b0;
         tick(3);
         link.pll_lock = 1'b1;
         if (i == 1) begin
            check("t5.holdoff", 32'(link.state), 32'd5);
            link.frame_start = 1'b1;
            tick(1);
            link.frame_start = 1'b0;
            check("t5.fs_holdoff", 32'(link.state), 32'd5);
            tick(15);
         end else begin
            tick(16);
         end
         if (i == 252) check("t5.fault254", 32'(link.fault_count), 32'd254);
         if (i == 253) check("t5.fault255", 32'(link.fault_count), 32'd255);
      end
      check("t5.saturated", 32'(link.fault_count), 32'd255);
      check("t5.retry", 32'(link.state), 32'd1);

      // 6: async reset mid-RUN
      tick(8);
      tick(4);
      link.frame_start = 1'b1;
      tick(1);
      link.frame_start = 1'b0;
      check("t6.run", 32'(link.state), 32'd4);
      #2 rst = 1'b1;
      #1;
      check_out("t6.async", 3'd0, 1'b0, 1'b0, 1'b0);
      check("t6.fault", 32'(link.fault_count), 32'd0);
      link.pll_lock = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("t6.edge0", 32'(link.state), 32'd1);
      link.pll_lock = 1'b1;
      tick(9);
      check("t6.edge9", 32'(link.state), 32'd1);
      tick(1);
      check_out("t6.edge10", 3'd2, 1'b1, 1'b0, 1'b0);
      tick(4);
      check_out("t6.edge14", 3'd3, 1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
